// File: rtl/mem_responder_if.sv
// Tagged block-memory bus between the accelerator (master) and the memory responder (slave).
interface mem_responder_if;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_transaction_tag;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_data_tag;

    modport master (
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        input  mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag
    );

    modport slave (
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        output mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: grants the lowest free tag on each LOAD/STORE and returns
// tagged data a fixed LATENCY cycles later; includes a backdoor preload port.
module mem_responder #(
    parameter int  DEPTH    = 4096,
    parameter int  LATENCY  = 8,
    parameter int  NUM_TAGS = 15,
    localparam int IDX_W    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    mem_responder_if.slave   bus,
    input  logic             load_we,
    input  logic [IDX_W-1:0] load_idx,
    input  logic [63:0]      load_data
);
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    logic [63:0]                mem_q [DEPTH];
    logic [NUM_TAGS-1:0]        free_q, free_d;
    logic [LATENCY:1]           vld_q;
    logic [LATENCY:1][3:0]      tag_q;
    logic [LATENCY:1][63:0]     data_q;

    logic             is_load, is_store, in_range, accept;
    logic [IDX_W-1:0] idx;
    logic [3:0]       grant_tag;
    logic [63:0]      rsp_d;

    assign is_load  = !rst && (bus.proc2mem_command == CMD_LOAD);
    assign is_store = !rst && (bus.proc2mem_command == CMD_STORE);
    assign in_range = (bus.proc2mem_addr >> (IDX_W + 3)) == 32'd0;
    assign idx      = bus.proc2mem_addr[3 +: IDX_W];

    // Priority pick of the lowest free tag; depends only on the registered mask.
    always_comb begin
        grant_tag = 4'd0;
        for (int i = NUM_TAGS - 1; i >= 0; i--)
            if (free_q[i]) grant_tag = 4'(i + 1);
    end

    assign bus.mem2proc_transaction_tag = (is_load || is_store) ? grant_tag : 4'd0;
    assign accept = (bus.mem2proc_transaction_tag != 4'd0);

    // The responding tag cannot be the one granted this cycle, since it is still busy.
    always_comb begin
        free_d = free_q;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (vld_q[LATENCY] && tag_q[LATENCY] == 4'(i + 1)) free_d[i] = 1'b1;
            if (accept && grant_tag == 4'(i + 1))              free_d[i] = 1'b0;
        end
    end

    always_comb begin
        rsp_d = 64'd0;
        if (is_store)      rsp_d = bus.proc2mem_data;
        else if (in_range) rsp_d = mem_q[idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            free_q <= '1;
            vld_q  <= '0;
            tag_q  <= '0;
            data_q <= '0;
        end else begin
            free_q    <= free_d;
            vld_q[1]  <= accept;
            tag_q[1]  <= accept ? grant_tag : 4'd0;
            data_q[1] <= accept ? rsp_d : 64'd0;
            for (int i = 2; i <= LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                tag_q[i]  <= tag_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    // Contents survive reset; a same-index accepted STORE overrides the backdoor.
    always_ff @(posedge clk) begin
        if (load_we)                        mem_q[load_idx] <= load_data;
        if (accept && is_store && in_range) mem_q[idx]      <= bus.proc2mem_data;
    end

    assign bus.mem2proc_data_tag = vld_q[LATENCY] ? tag_q[LATENCY] : 4'd0;
    assign bus.mem2proc_data     = data_q[LATENCY];
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: directed vector tables plus random traffic against a
// cycle-calendar model of tag ownership, memory contents and response timing.
module tb_mem_responder;
    localparam int DEPTH = 4096;
    localparam int LAT   = 8;
    localparam int NT    = 4;
    localparam int IW    = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_we;
    logic [IW-1:0] load_idx;
    logic [63:0]   load_data;

    mem_responder_if bus ();

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .NUM_TAGS(NT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .load_we   (load_we),
        .load_idx  (load_idx),
        .load_data (load_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit idle_data_chk = 1'b0;

    // Model: cycle from which each tag may be granted, memory image, response calendar.
    int          free_at [1:NT];
    logic [63:0] mmem    [int];
    logic [3:0]  rtag    [int];
    logic [63:0] rdata   [int];

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] data;
        int          exp_tag;   // -1: model only
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] cmd, input logic [31:0] addr,
                        input logic [63:0] d, input logic we, input logic [IW-1:0] li,
                        input logic [63:0] ld, input int exp_tag);
        logic [3:0]  mt;
        logic [63:0] rd;
        int          idx;
        bit          inr, isreq, st_hit;
        @(negedge clk);
        rst = r;
        bus.proc2mem_command = cmd;
        bus.proc2mem_addr    = addr;
        bus.proc2mem_data    = d;
        load_we   = we;
        load_idx  = li;
        load_data = ld;
        #1;
        isreq = !r && (cmd == 2'd1 || cmd == 2'd2);
        mt = 4'd0;
        if (isreq)
            for (int t = NT; t >= 1; t--)
                if (free_at[t] <= cyc) mt = 4'(t);
        chk("txn_tag", 64'(bus.mem2proc_transaction_tag), 64'(mt));
        if (exp_tag >= 0) chk("tbl_tag", 64'(bus.mem2proc_transaction_tag), 64'(exp_tag));
        if (rtag.exists(cyc)) begin
            chk("rsp_tag", 64'(bus.mem2proc_data_tag), 64'(rtag[cyc]));
            chk("rsp_data", bus.mem2proc_data, rdata[cyc]);
        end else begin
            chk("rsp_tag", 64'(bus.mem2proc_data_tag), 64'd0);
            if (idle_data_chk) chk("idle_data", bus.mem2proc_data, 64'd0);
        end
        inr = addr < 32'(DEPTH * 8);
        idx = int'(addr[3 +: IW]);
        st_hit = (mt != 0) && (cmd == 2'd2) && inr;
        if (r) begin
            for (int t = 1; t <= NT; t++) free_at[t] = 0;
            rtag.delete();
            rdata.delete();
        end else if (mt != 0) begin
            if (cmd == 2'd1) rd = inr ? mmem[idx] : 64'd0;
            else             rd = d;
            free_at[mt]     = cyc + LAT + 1;
            rtag[cyc + LAT]  = mt;
            rdata[cyc + LAT] = rd;
        end
        if (we && !(st_hit && int'(li) == idx)) mmem[int'(li)] = ld;
        if (st_hit) mmem[idx] = d;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 32'd0, 64'd0, 1'b0, '0, 64'd0, -1);
    endtask

    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++)
            step(1'b0, tbl[i].cmd, tbl[i].addr, tbl[i].data, 1'b0, '0, 64'd0, tbl[i].exp_tag);
        tbl.delete();
    endtask

    initial begin
        rst = 1'b1;
        bus.proc2mem_command = 2'd0;
        bus.proc2mem_addr    = 32'd0;
        bus.proc2mem_data    = 64'd0;
        load_we = 1'b0; load_idx = '0; load_data = 64'd0;
        for (int t = 1; t <= NT; t++) free_at[t] = 0;
        @(posedge clk);

        // Reset held with a LOAD pending: grant forced to 0, then 20 idle cycles all zero.
        idle_data_chk = 1'b1;
        step(1'b1, 2'd1, 32'h0, 64'd0, 1'b0, '0, 64'd0, 0);
        step(1'b1, 2'd1, 32'h0, 64'd0, 1'b0, '0, 64'd0, 0);
        idle(20);
        idle_data_chk = 1'b0;

        // Preload blocks 0..15 through the backdoor (block 5 gets the pattern).
        for (int i = 0; i < 16; i++)
            step(1'b0, 2'd0, 32'd0, 64'd0, 1'b1, IW'(i),
                 (i == 5) ? 64'hDEAD_BEEF_0123_4567 : 64'hA5A5_0000_0000_0000 | 64'(i), -1);
        tbl.push_back('{2'd1, 32'h28, 64'd0, 1});
        run_tbl();
        idle(LAT + 2);

        // Store then load to the same block; second request gets tag 2.
        tbl.push_back('{2'd2, 32'h40, 64'h11, 1});
        tbl.push_back('{2'd1, 32'h40, 64'd0,  2});
        run_tbl();
        idle(LAT + 2);

        // Back-to-back loads exhaust the four tags; tag 1 returns at cycle 9.
        for (int i = 0; i < 10; i++)
            tbl.push_back('{2'd1, 32'h40, 64'd0, (i < 4) ? i + 1 : (i == 9) ? 1 : 0});
        run_tbl();
        idle(LAT + 2);

        // Out-of-range store dropped, load returns 0, block 0 intact; command 3 is ignored.
        tbl.push_back('{2'd2, 32'h8000, 64'h99, 1});
        tbl.push_back('{2'd1, 32'h8000, 64'd0,  2});
        tbl.push_back('{2'd1, 32'h0,    64'd0,  3});
        tbl.push_back('{2'd3, 32'h0,    64'd0,  0});
        run_tbl();
        idle(LAT + 2);

        // Same-cycle backdoor and STORE to one block: the STORE must win.
        step(1'b0, 2'd2, 32'h80, 64'hAAAA, 1'b1, IW'(16), 64'hBBBB, 1);
        step(1'b0, 2'd1, 32'h80, 64'd0, 1'b0, '0, 64'd0, 2);
        idle(LAT + 2);

        // Reset mid-flight: the outstanding response vanishes and tag 1 is free again.
        step(1'b0, 2'd1, 32'h28, 64'd0, 1'b0, '0, 64'd0, 1);
        idle(2);
        step(1'b1, 2'd0, 32'd0, 64'd0, 1'b0, '0, 64'd0, 0);
        idle(12);
        step(1'b0, 2'd1, 32'h28, 64'd0, 1'b0, '0, 64'd0, 1);
        idle(LAT + 2);

        // Random traffic over blocks 0..15 plus out-of-range addresses.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            logic [IW-1:0] bi;
            a  = ($urandom_range(0, 9) == 0) ? 32'h8000 + 32'($urandom_range(0, 255)) * 8
                                             : 32'($urandom_range(0, 15)) * 8 + 32'($urandom_range(0, 7));
            bi = IW'($urandom_range(0, 15));
            step(($urandom_range(0, 149) == 0), 2'($urandom_range(0, 3)), a,
                 {$urandom, $urandom}, ($urandom_range(0, 3) == 0), bi, {$urandom, $urandom}, -1);
        end
        idle(LAT + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
